// File: rtl/gmii_pkg.sv
// Shared constants, state encoding and CRC-32 helpers for the GMII receive path.
package gmii_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  // Good-frame residue, expressed MSB-first (bit-reversed w.r.t. the reflected register).
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } rx_state_e;

  // One byte through the reflected IEEE 802.3 CRC-32, LSB of the byte first.
  function automatic logic [31:0] crc32_byte_next(input logic [31:0] crc,
                                                  input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_byte_chk.sv
// Byte-wide reflected CRC-32 register with good-frame residue detection.
module crc32_byte_chk
  import gmii_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       init_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic       ok_o
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // Next CRC value: init wins, otherwise fold in the sampled byte.
  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = CRC_INIT;
    end else if (en_i) begin
      crc_d = crc32_byte_next(crc_q, data_i);
    end
  end

  // CRC state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  // The register holds the reflected residue, so compare it reversed.
  assign ok_o = (bit_rev32(crc_q) == CRC_RESIDUE);

endmodule

// File: rtl/gmii_rx_fcs_ctrl.sv
// GMII receive frame sequencer: preamble/SFD strip, CRC check, length and
// end-of-frame status with saturating good/bad frame counters.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for rx_dv with a preamble byte
//   PRE   | inside preamble, waiting for SFD
//   DATA  | frame body (DA..FCS): CRC and length counting
//   DROP  | malformed start, discard until rx_dv falls
module gmii_rx_fcs_ctrl
  import gmii_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_dv_i,
  input  logic             rx_er_i,
  input  logic [7:0]       rxd_i,
  input  logic             stat_clr_i,
  output logic             status_valid_o,
  output logic             frame_good_o,
  output logic             crc_err_o,
  output logic             runt_o,
  output logic             oversize_o,
  output logic             phy_err_o,
  output logic [LEN_W-1:0] frame_len_o,
  output logic [31:0]      good_cnt_o,
  output logic [31:0]      bad_cnt_o
);

  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);

  rx_state_e        state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             phy_q, phy_d;
  logic             crc_init, crc_en, crc_ok, load_status;

  logic             valid_q, valid_d;
  logic             good_q, good_d;
  logic             crc_err_q, crc_err_d;
  logic             runt_q, runt_d;
  logic             over_q, over_d;
  logic             phy_err_q, phy_err_d;
  logic [LEN_W-1:0] flen_q, flen_d;
  logic [31:0]      good_cnt_q, good_cnt_d;
  logic [31:0]      bad_cnt_q, bad_cnt_d;

  crc32_byte_chk u_crc (
    .clk    (clk),
    .reset  (reset),
    .init_i (crc_init),
    .en_i   (crc_en),
    .data_i (rxd_i),
    .ok_o   (crc_ok)
  );

  // Frame state machine and per-cycle strobes.
  always_comb begin
    state_d     = state_q;
    crc_init    = 1'b0;
    crc_en      = 1'b0;
    load_status = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_dv_i) begin
          state_d = (rxd_i == PREAMBLE_BYTE) ? PRE : DROP;
        end
      end
      PRE: begin
        if (!rx_dv_i) begin
          state_d = IDLE;
        end else if (rxd_i == PREAMBLE_BYTE) begin
          state_d = PRE;
        end else if (rxd_i == SFD_BYTE) begin
          state_d  = DATA;
          crc_init = 1'b1;
        end else begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (rx_dv_i) begin
          crc_en = 1'b1;
        end else begin
          state_d     = IDLE;
          load_status = 1'b1;
        end
      end
      DROP: begin
        if (!rx_dv_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Length counter (saturating) and sticky PHY error, both restarted at SFD.
  always_comb begin
    len_d = len_q;
    phy_d = phy_q;
    if (crc_init) begin
      len_d = '0;
      phy_d = 1'b0;
    end else if (crc_en) begin
      if (len_q != LEN_SAT) begin
        len_d = len_q + LEN_W'(1);
      end
      if (rx_er_i) begin
        phy_d = 1'b1;
      end
    end
  end

  // End-of-frame status capture; flags hold until the next frame ends.
  always_comb begin
    valid_d   = load_status;
    good_d    = good_q;
    crc_err_d = crc_err_q;
    runt_d    = runt_q;
    over_d    = over_q;
    phy_err_d = phy_err_q;
    flen_d    = flen_q;
    if (load_status) begin
      crc_err_d = !crc_ok;
      runt_d    = (len_q < LEN_MIN);
      over_d    = (len_q > LEN_MAX);
      phy_err_d = phy_q;
      good_d    = crc_ok && !(len_q < LEN_MIN) && !(len_q > LEN_MAX) && !phy_q;
      flen_d    = len_q;
    end
  end

  // Saturating frame counters, fed from the registered status strobe.
  always_comb begin
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (stat_clr_i) begin
      good_cnt_d = '0;
      bad_cnt_d  = '0;
    end else if (valid_q) begin
      if (good_q && (good_cnt_q != 32'hFFFF_FFFF)) begin
        good_cnt_d = good_cnt_q + 32'd1;
      end
      if (!good_q && (bad_cnt_q != 32'hFFFF_FFFF)) begin
        bad_cnt_d = bad_cnt_q + 32'd1;
      end
    end
  end

  // All controller state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      phy_q      <= 1'b0;
      valid_q    <= 1'b0;
      good_q     <= 1'b0;
      crc_err_q  <= 1'b0;
      runt_q     <= 1'b0;
      over_q     <= 1'b0;
      phy_err_q  <= 1'b0;
      flen_q     <= '0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      phy_q      <= phy_d;
      valid_q    <= valid_d;
      good_q     <= good_d;
      crc_err_q  <= crc_err_d;
      runt_q     <= runt_d;
      over_q     <= over_d;
      phy_err_q  <= phy_err_d;
      flen_q     <= flen_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign status_valid_o = valid_q;
  assign frame_good_o   = good_q;
  assign crc_err_o      = crc_err_q;
  assign runt_o         = runt_q;
  assign oversize_o     = over_q;
  assign phy_err_o      = phy_err_q;
  assign frame_len_o    = flen_q;
  assign good_cnt_o     = good_cnt_q;
  assign bad_cnt_o      = bad_cnt_q;

endmodule

// File: tb/tb_gmii_rx_fcs_ctrl.sv
// Directed bench for gmii_rx_fcs_ctrl: vector table of frames plus hand
// sequences for back-to-back, clear collision, bad preamble and reset.
module tb_gmii_rx_fcs_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_dv, rx_er, stat_clr;
  logic [7:0]  rxd;
  logic        status_valid, frame_good, crc_err, runt, oversize, phy_err;
  logic [15:0] frame_len;
  logic [31:0] good_cnt, bad_cnt;

  int checks   = 0;
  int failures = 0;
  int n_strobe = 0;
  int exp_good = 0;
  int exp_bad  = 0;

  gmii_rx_fcs_ctrl #(.MIN_LEN(64), .MAX_LEN(1518), .LEN_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_dv_i        (rx_dv),
    .rx_er_i        (rx_er),
    .rxd_i          (rxd),
    .stat_clr_i     (stat_clr),
    .status_valid_o (status_valid),
    .frame_good_o   (frame_good),
    .crc_err_o      (crc_err),
    .runt_o         (runt),
    .oversize_o     (oversize),
    .phy_err_o      (phy_err),
    .frame_len_o    (frame_len),
    .good_cnt_o     (good_cnt),
    .bad_cnt_o      (bad_cnt)
  );

  always #4 clk = ~clk;

  // Count every cycle in which the status strobe is high.
  always @(negedge clk) begin
    if (status_valid === 1'b1) n_strobe++;
  end

  initial begin
    #400us;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int n_pay;
    bit flip;
    int er_at;
    int e_len;
    bit e_good, e_crc, e_runt, e_over, e_phy;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      if ((r[0] ^ d[k]) == 1'b1) r = (r >> 1) ^ 32'hEDB88320;
      else                       r = r >> 1;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic er);
    @(negedge clk);
    rx_dv = 1'b1;
    rxd   = b;
    rx_er = er;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_dv = 1'b0;
      rxd   = 8'h00;
      rx_er = 1'b0;
    end
  endtask

  // Preamble, SFD, n_pay payload bytes and correct FCS (computed before flip).
  task automatic send_frame(input int n_pay, input bit flip, input int er_at, input int seed);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    repeat (7) send_byte(8'h55, 1'b0);
    send_byte(8'hD5, 1'b0);
    for (int i = 0; i < n_pay; i++) begin
      b = 8'(i * 7 + seed);
      c = crc_step(c, b);
      if (flip && i == 10) b = b ^ 8'h01;
      send_byte(b, (i + 1) == er_at);
    end
    c = ~c;
    send_byte(c[7:0],   (n_pay + 1) == er_at);
    send_byte(c[15:8],  1'b0);
    send_byte(c[23:16], 1'b0);
    send_byte(c[31:24], 1'b0);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_good_cnt"}, good_cnt, exp_good);
    chk({tag, "_bad_cnt"},  bad_cnt,  exp_bad);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},    {31'd0, status_valid}, 0);
    chk({tag, "_good"},     {31'd0, frame_good},   0);
    chk({tag, "_flags"},    {28'd0, crc_err, runt, oversize, phy_err}, 0);
    chk({tag, "_len"},      {16'd0, frame_len},    0);
    chk({tag, "_good_cnt"}, good_cnt, 0);
    chk({tag, "_bad_cnt"},  bad_cnt,  0);
  endtask

  initial begin
    int s0;
    //        n_pay flip er  len   good crc runt over phy
    vecs[0] = '{60,   0, 0,   64,  1, 0, 0, 0, 0};
    vecs[1] = '{60,   1, 0,   64,  0, 1, 0, 0, 0};
    vecs[2] = '{56,   0, 0,   60,  0, 0, 1, 0, 0};
    vecs[3] = '{59,   0, 0,   63,  0, 0, 1, 0, 0};
    vecs[4] = '{1514, 0, 0, 1518,  1, 0, 0, 0, 0};
    vecs[5] = '{1515, 0, 0, 1519,  0, 0, 0, 1, 0};
    vecs[6] = '{1596, 0, 0, 1519,  0, 0, 0, 1, 0};
    vecs[7] = '{60,   0, 20,  64,  0, 0, 0, 0, 1};
    vecs[8] = '{60,   0, 0,   64,  1, 0, 0, 0, 0};

    reset = 1'b1; rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'h00; stat_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    idle(2);

    for (int v = 0; v < 9; v++) begin
      s0 = n_strobe;
      send_frame(vecs[v].n_pay, vecs[v].flip, vecs[v].er_at, v + 3);
      idle(4);
      if (vecs[v].e_good) exp_good++; else exp_bad++;
      chk($sformatf("v%0d_strobes", v),  n_strobe - s0, 1);
      chk($sformatf("v%0d_len", v),      {16'd0, frame_len}, vecs[v].e_len);
      chk($sformatf("v%0d_good", v),     {31'd0, frame_good}, {31'd0, vecs[v].e_good});
      chk($sformatf("v%0d_crc_err", v),  {31'd0, crc_err},    {31'd0, vecs[v].e_crc});
      chk($sformatf("v%0d_runt", v),     {31'd0, runt},       {31'd0, vecs[v].e_runt});
      chk($sformatf("v%0d_oversize", v), {31'd0, oversize},   {31'd0, vecs[v].e_over});
      chk($sformatf("v%0d_phy_err", v),  {31'd0, phy_err},    {31'd0, vecs[v].e_phy});
      chk_counts($sformatf("v%0d", v));
    end

    // Back-to-back good frames, single idle cycle between them.
    s0 = n_strobe;
    send_frame(60, 0, 0, 40);
    idle(1);
    send_frame(60, 0, 0, 41);
    idle(4);
    exp_good += 2;
    chk("b2b_strobes", n_strobe - s0, 2);
    chk("b2b_good", {31'd0, frame_good}, 1);
    chk_counts("b2b");

    // Plain clear.
    @(negedge clk); stat_clr = 1'b1;
    @(negedge clk); stat_clr = 1'b0;
    exp_good = 0; exp_bad = 0;
    chk_counts("clr");

    // Clear coinciding with a good-frame increment: clear wins.
    s0 = n_strobe;
    send_frame(60, 0, 0, 50);
    idle(1);
    @(negedge clk); stat_clr = 1'b1;
    @(negedge clk); stat_clr = 1'b0;
    idle(2);
    chk("clrhit_strobes", n_strobe - s0, 1);
    chk("clrhit_good", {31'd0, frame_good}, 1);
    chk_counts("clrhit");

    // Bad preamble: 0x55 then 0x12, later an SFD must not revive it.
    s0 = n_strobe;
    send_byte(8'h55, 1'b0); send_byte(8'h12, 1'b0);
    send_byte(8'h55, 1'b0); send_byte(8'hD5, 1'b0);
    repeat (70) send_byte(8'hAA, 1'b0);
    idle(4);
    chk("badpre_strobes", n_strobe - s0, 0);
    chk("badpre_len", {16'd0, frame_len}, 64);
    chk_counts("badpre");

    // rx_dv drops inside preamble.
    s0 = n_strobe;
    repeat (3) send_byte(8'h55, 1'b0);
    idle(4);
    chk("preabort_strobes", n_strobe - s0, 0);
    chk_counts("preabort");

    // Good frame so counters/status are non-zero before the reset.
    send_frame(60, 0, 0, 60);
    idle(4);
    exp_good++;
    chk_counts("prerst");

    // Reset at byte 30 of a frame; rest of the frame must be dropped.
    s0 = n_strobe;
    repeat (7) send_byte(8'h55, 1'b0);
    send_byte(8'hD5, 1'b0);
    repeat (30) send_byte(8'hAA, 1'b0);
    @(negedge clk); reset = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge clk); reset = 1'b0;
    repeat (34) send_byte(8'hAA, 1'b0);
    idle(4);
    exp_good = 0; exp_bad = 0;
    chk("midrst_strobes", n_strobe - s0, 0);
    chk_counts("midrst_after");

    s0 = n_strobe;
    send_frame(60, 0, 0, 70);
    idle(4);
    exp_good = 1;
    chk("postrst_strobes", n_strobe - s0, 1);
    chk("postrst_good", {31'd0, frame_good}, 1);
    chk("postrst_len", {16'd0, frame_len}, 64);
    chk_counts("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
